// File: rtl/adder_sum_accumulator.sv
// Accumulates a programmed number of 5-bit ripple-adder results into an ACC_W-bit total.
// Presents the total and a sticky overflow flag on a valid/ready output port.
module adder_sum_accumulator #(
   parameter int ACC_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       num_terms,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_sum,
   input  logic             in_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // A producer holds valid and data stable until that edge. in_ready and out_valid
   // come only from the registered state, so they never depend on in_valid or out_ready.

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [3:0]       remaining_q, remaining_d;

   logic [ACC_W:0]   term_ext;
   logic [ACC_W:0]   sum_ext;
   logic             beat;
   logic             out_hs;

   assign term_ext = {{(ACC_W-4){1'b0}}, in_cout, in_sum};
   assign sum_ext  = {1'b0, acc_q} + term_ext;

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         S_ACCUM: in_ready  = 1'b1;
         S_DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

   assign beat   = in_valid && in_ready;
   assign out_hs = out_valid && out_ready;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      remaining_d = remaining_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d       = '0;
               ovf_d       = 1'b0;
               remaining_d = num_terms;
               state_d     = (num_terms == 4'd0) ? S_DONE : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (beat) begin
               acc_d       = sum_ext[ACC_W-1:0];
               ovf_d       = ovf_q | sum_ext[ACC_W];
               remaining_d = remaining_q - 4'd1;
               if (remaining_q == 4'd1) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            // acc/ovf stay put after the handshake; only the next start clears them.
            if (out_hs) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         remaining_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         remaining_q <= remaining_d;
      end
   end

   assign out_acc   = acc_q;
   assign out_ovf   = ovf_q;
   assign busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator: table-driven runs plus hand-written
// sequences for stalls, back-pressure, zero-length runs and mid-run reset.
module tb_adder_sum_accumulator;

   localparam int ACC_W = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [3:0]       num_terms;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_sum;
   logic             in_cout;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_acc;
   logic             out_ovf;
   logic             busy;
   logic [1:0]       dbg_state;

   int checks;
   int errors;

   logic [ACC_W:0] exp_q[$];

   typedef struct packed {
      logic [3:0]       n;
      logic [15:0][4:0] terms;
      logic [ACC_W-1:0] acc;
      logic             ovf;
   } vec_t;

   vec_t vecs[8];

   adder_sum_accumulator #(.ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_terms (num_terms),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .in_cout   (in_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_ovf   (out_ovf),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_term(input logic [4:0] t);
      in_valid = 1'b1;
      {in_cout, in_sum} = t;
   endtask

   // Start a run of n terms, feed them without gaps, then consume the result.
   task automatic run_vec(input vec_t v, input string name);
      logic [ACC_W:0] exp;
      exp_q.push_back({v.ovf, v.acc});
      start = 1'b1;
      num_terms = v.n;
      tick();
      start = 1'b0;
      for (int i = 0; i < int'(v.n); i++) begin
         chk({name, "_in_ready"}, in_ready, 1);
         chk({name, "_early_valid"}, out_valid, 0);
         drive_term(v.terms[i]);
         tick();
      end
      in_valid = 1'b0;
      chk({name, "_out_valid"}, out_valid, 1);
      chk({name, "_busy_done"}, busy, 1);
      exp = exp_q.pop_front();
      chk({name, "_acc"}, out_acc, exp[ACC_W-1:0]);
      chk({name, "_ovf"}, out_ovf, exp[ACC_W]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({name, "_busy_after"}, busy, 0);
      chk({name, "_valid_after"}, out_valid, 0);
      chk({name, "_acc_kept"}, out_acc, exp[ACC_W-1:0]);
   endtask

   initial begin
      vec_t v;
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      start = 1'b0;
      num_terms = 4'd0;
      in_valid = 1'b0;
      in_sum = 4'd0;
      in_cout = 1'b0;
      out_ready = 1'b0;

      // table of runs with hand-computed totals (ACC_W = 8)
      for (int i = 0; i < 8; i++) vecs[i].terms = {16{5'd31}};
      vecs[0].n = 4'd4;  vecs[0].acc = 8'd124; vecs[0].ovf = 1'b0;
      vecs[1].n = 4'd9;  vecs[1].acc = 8'd23;  vecs[1].ovf = 1'b1;
      vecs[2].n = 4'd0;  vecs[2].acc = 8'd0;   vecs[2].ovf = 1'b0;
      vecs[3].n = 4'd1;  vecs[3].terms[0] = 5'd3;  vecs[3].acc = 8'd3; vecs[3].ovf = 1'b0;
      vecs[4].n = 4'd2;  vecs[4].terms[0] = 5'd17; vecs[4].terms[1] = 5'd16;
      vecs[4].acc = 8'd33; vecs[4].ovf = 1'b0;
      vecs[5].n = 4'd15; vecs[5].acc = 8'd209; vecs[5].ovf = 1'b1;
      vecs[6].n = 4'd8;  vecs[6].acc = 8'd248; vecs[6].ovf = 1'b0;
      vecs[7].n = 4'd9;  vecs[7].terms[8] = 5'd8; vecs[7].acc = 8'd0; vecs[7].ovf = 1'b1;

      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_acc", out_acc, 0);
      chk("rst_out_ovf", out_ovf, 0);

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // stalled input: 5, three idle cycles, 7, 2 -> 14
      start = 1'b1; num_terms = 4'd3;
      tick();
      start = 1'b0;
      drive_term(5'd5);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("gap_in_ready", in_ready, 1);
         chk("gap_no_valid", out_valid, 0);
         tick();
      end
      drive_term(5'd7);
      tick();
      chk("gap_in_ready2", in_ready, 1);
      drive_term(5'd2);
      tick();
      in_valid = 1'b0;
      chk("gap_out_valid", out_valid, 1);
      chk("gap_acc", out_acc, 14);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("gap_busy_after", busy, 0);

      // back-pressure in DONE with start and in_valid noise
      start = 1'b1; num_terms = 4'd1;
      tick();
      start = 1'b0;
      drive_term(5'd10);
      tick();
      for (int i = 0; i < 5; i++) begin
         start = 1'b1;
         num_terms = 4'd2;
         drive_term(5'($urandom_range(0, 31)));
         tick();
         chk("bp_valid", out_valid, 1);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_acc", out_acc, 10);
         chk("bp_ovf", out_ovf, 0);
      end
      // start in the handshake cycle must be ignored
      out_ready = 1'b1;
      start = 1'b1;
      tick();
      out_ready = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      chk("bp_idle_busy", busy, 0);
      tick();
      chk("bp_no_new_run", busy, 0);
      chk("bp_acc_kept", out_acc, 10);

      // reset mid-run after 20 + 20
      start = 1'b1; num_terms = 4'd4;
      tick();
      start = 1'b0;
      drive_term(5'd20);
      tick();
      drive_term(5'd20);
      tick();
      chk("mid_acc", out_acc, 40);
      rst_n = 1'b0;
      drive_term(5'd20);
      tick();
      rst_n = 1'b1;
      in_valid = 1'b0;
      chk("mrst_busy", busy, 0);
      chk("mrst_in_ready", in_ready, 0);
      chk("mrst_out_valid", out_valid, 0);
      chk("mrst_out_acc", out_acc, 0);
      chk("mrst_out_ovf", out_ovf, 0);
      v = vecs[3];
      run_vec(v, "after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got 0 expected 1");
      $fatal(1);
   end

endmodule

// File: doc/adder_sum_accumulator.md
# adder_sum_accumulator

Sequential stage directly downstream of the 4-bit ripple adder. It consumes one 5-bit adder result ({cout, sum[3:0]}) per accepted beat and accumulates a programmed number of results into a wider running total. It then presents the total with a sticky overflow flag on a valid/ready output. Adder results arrive over a valid/ready input, so the block can be back-pressured, and the upstream operand source can be throttled.

## Interface
Parameters:
- ACC_W, 8, accumulator and out_acc width in bits; legal range 5..16.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  single-cycle request to begin a new accumulation; sampled only in IDLE.
- num_terms  input  4  number of adder results to accumulate; sampled with start; 0 is legal.
- in_valid  input  1  adder result on in_sum/in_cout is valid.
- in_ready  output  1  block accepts a result this cycle.
- in_sum  input  4  adder sum[3:0].
- in_cout  input  1  adder carry-out.
- out_valid  output  1  out_acc/out_ovf hold a completed result.
- out_ready  input  1  consumer accepts the result.
- out_acc  output  ACC_W  accumulated total, modulo 2^ACC_W.
- out_ovf  output  1  set if any addition carried out of bit ACC_W-1 during this accumulation.
- busy  output  1  state is not IDLE.

## Operation
- The FSM has three states: IDLE, ACCUM and DONE. Its state register and all other registers are updated only on the rising edge of clk.
- Term value is the zero-extended 5-bit vector {in_cout, in_sum}, range 0..31.
- Beat: a beat occurs in a cycle where in_valid && in_ready. Output handshake: a result is accepted in a cycle where out_valid && out_ready.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start with num_terms!=0: acc<=0, ovf<=0, remaining<=num_terms, go to ACCUM.
  - On start with num_terms==0: acc<=0, ovf<=0, go directly to DONE.
- ACCUM:
  - in_ready=1.
  - On each beat: {carry, acc} <= acc + term; ovf <= ovf | carry; remaining <= remaining-1.
  - If remaining==1 on the beat, go to DONE. Otherwise stay in ACCUM.
  - Cycles without in_valid leave all state unchanged.
- DONE:
  - out_valid=1, in_ready=0; out_acc=acc, out_ovf=ovf.
  - All outputs hold stable until the output handshake occurs. On the handshake, go to IDLE.
  - acc and ovf retain their values after leaving DONE. Only the next start clears them.
- start is ignored in ACCUM and DONE. It is not queued.
- Arithmetic wraps modulo 2^ACC_W. ovf is sticky within an accumulation.
- busy = (state != IDLE).

## Timing
- Reset is synchronous. When rst_n is low at a rising edge, the next state is:
  - state=IDLE, acc=0, ovf=0, remaining=0.
  - in_ready=0, out_valid=0, out_acc=0, out_ovf=0, busy=0.
- Reset overrides every other input, including a start, beat or handshake in the same cycle. It aborts an accumulation mid-stream and discards any pending DONE result.
- in_ready, out_valid and busy are decoded from the registered state only. There is no combinational path from in_valid or out_ready to any output.
- Throughput is one term per cycle while in ACCUM.
- Result latency:
  - out_valid rises on the edge that accepts the last beat, i.e. it is visible the cycle after the last beat is presented.
  - For num_terms==0, out_valid rises on the edge that samples start.
- Minimum spacing: the earliest new start is the first cycle after the output handshake, since the block is then in IDLE. A start in the same cycle as the handshake is ignored.
- Back-to-back runs: minimum period is num_terms + 2 cycles, assuming in_valid and out_ready are held high.

## Test plan
- Reset, then start with num_terms=4 and four beats of {1,1111} (31 each):
  - out_valid rises 1 cycle after the 4th beat.
  - out_acc=124, out_ovf=0.
  - After out_ready is asserted: busy=0 next cycle.
- Start with num_terms=9 and nine beats of 31, ACC_W=8: out_acc=23 (279 mod 256), out_ovf=1.
- Start with num_terms=3; feed 5, then hold in_valid=0 for 3 cycles, then feed 7 and 2:
  - in_ready stays 1 throughout ACCUM.
  - out_acc=14; out_valid rises 1 cycle after the final beat.
- Hold out_ready=0 for 5 cycles in DONE while pulsing start and driving in_valid:
  - out_acc and out_ovf remain stable; in_ready=0.
  - After the handshake, the block is in IDLE with no new run started.
- Start with num_terms=0: out_valid=1 the next cycle, with out_acc=0 and out_ovf=0.
- Assert rst_n=0 for one cycle after 2 of 4 beats (acc=40):
  - Next cycle: busy=0, in_ready=0, out_valid=0, out_acc=0.
  - A new start with num_terms=1 and term 3 gives out_acc=3.
